conv_frame_sched: RTL and testbench
===================================

// Module: conv_frame_sched
// PURPOSE
//  Sequences one convolution layer through the sliding-window generator.
//  Per (output channel, input channel) pair: pulses frame_start, streams one
//  IMG_WIDTH x IMG_HEIGHT feature map from feature-map RAM as a pixel stream,
//  then counts returned window_valid pulses until the frame is drained.
//  Tags each window so the downstream MAC/accumulator knows first/last channel.
// PARAMETERS
//  DATA_WIDTH     16    pixel width
//  IMG_WIDTH      32    feature-map width (pixels)
//  IMG_HEIGHT     32    feature-map height (rows)
//  IN_CH          3     input channels per output channel
//  OUT_CH         8     output channels (kernels)
//  ADDR_WIDTH     16    RAM address width, >= clog2(IN_CH*IMG_WIDTH*IMG_HEIGHT)
//  DRAIN_TIMEOUT  4096  max cycles in DRAIN before error is flagged
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           async active-low reset
//  start        in   1           begin layer; sampled only in IDLE
//  abort        in   1           sync abort; return to IDLE, no done
//  base_addr    in   ADDR_WIDTH  RAM address of channel 0, pixel (0,0); latched on start
//  mem_rd_en    out  1           RAM read strobe
//  mem_addr     out  ADDR_WIDTH  RAM read address
//  mem_rd_data  in   DATA_WIDTH  RAM data, valid exactly 1 cycle after mem_rd_en
//  frame_start  out  1           1-cycle pulse to window generator
//  pixel_out    out  DATA_WIDTH  pixel to window generator (= mem_rd_data)
//  pixel_valid  out  1           mem_rd_en delayed 1 cycle
//  window_valid in   1           window-ready pulse from window generator
//  acc_first    out  1           window_valid & (ic_idx==0)
//  acc_last     out  1           window_valid & (ic_idx==IN_CH-1)
//  oc_idx       out  clog2(OUT_CH) current output channel
//  ic_idx       out  clog2(IN_CH)  current input channel
//  busy         out  1           high in any state except IDLE
//  done         out  1           1-cycle pulse after last frame drained
//  error        out  1           sticky drain timeout; cleared by next accepted start
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0: mem_rd_en, mem_addr, frame_start,
//    pixel_valid, pixel_out, busy, done, error, oc_idx, ic_idx.
//  - FSM: IDLE -start-> FSTART (frame_start=1, 1 cycle) -> STREAM -> DRAIN
//    -> NEXT -> FSTART | DONE -> IDLE. DONE lasts 1 cycle and drives done=1.
//  - STREAM: mem_rd_en=1 every cycle for exactly FP=IMG_WIDTH*IMG_HEIGHT cycles.
//    mem_addr = base + ic_idx*FP + pix, with pix 0..FP-1 in raster order.
//    FSTART->STREAM adds no bubble. pixel_valid trails mem_rd_en by 1 cycle.
//  - DRAIN: count window_valid pulses, including any arriving during STREAM,
//    from frame_start. Leave DRAIN when count==FP. Timeout: DRAIN_TIMEOUT
//    cycles in DRAIN without reaching FP -> set error, still advance to NEXT.
//  - NEXT: ic_idx++; on wrap (IN_CH-1 -> 0), oc_idx++. Go to DONE after the
//    (OUT_CH-1, IN_CH-1) pair, else to FSTART. Loop order: oc outer, ic inner.
//  - acc_first / acc_last: combinational on window_valid and the current
//    ic_idx; IN_CH==1 -> both assert together.
//  - Address math uses ADDR_WIDTH modular arithmetic; no overflow detection.
//  - start while busy: ignored. abort: any state -> IDLE next cycle; rd_en,
//    frame_start, pixel_valid drop immediately; done not pulsed; indices -> 0.
//  - abort and start in the same IDLE cycle: abort wins.
//  - window_valid in IDLE/DONE: ignored, not counted.
//  - rst_n asserted mid-layer: immediate return to reset values.
// STRUCTURE
//  - Shared package cnn_pkg: state enum (IDLE, FSTART, STREAM, DRAIN, NEXT,
//    DONE), localparam FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT, clog2 helper.
//  - Sub-module fmap_addr_gen: pixel counter plus channel-offset adder; load,
//    enable, last-pixel flag. FSM, drain counter and timeout stay in top.
// TESTING
//  - W=H=4, IN_CH=2, OUT_CH=2, base=0x100, ideal window model (16 windows
//    per frame) -> 4 frame_start pulses; addr 0x100..0x10F, 0x110..0x11F,
//    twice; done once; error=0.
//  - Check pixel_valid/pixel_out vs RAM model: data at rd cycle+1; exactly
//    16 pixel_valid per frame; no gap between FSTART and the first read.
//  - Model returns 15 windows, DRAIN_TIMEOUT=20 -> error set after 20 DRAIN
//    cycles; sequence continues; error stays 1 until the next start.
//  - abort mid-STREAM of (oc1, ic0) -> next cycle IDLE, busy=0, rd_en=0, no
//    done; new start runs a full layer from (0,0) with error cleared.
//  - IN_CH=1 -> acc_first and acc_last both high on every window; start
//    pulsed while busy -> no effect on sequence.
//  - rst_n low during DRAIN -> all outputs 0 asynchronously; idle after release.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared state encoding and sizing helpers for the convolution frame scheduler.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FSTART,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } sched_state_t;

    localparam int unsigned IMG_WIDTH_DEF  = 32;
    localparam int unsigned IMG_HEIGHT_DEF = 32;
    localparam int unsigned FRAME_PIXELS   = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

    // Ceiling log2, floored at 1 so a single-entry range still gets a bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fmap_addr_gen.sv
// Raster pixel counter plus latched channel base; produces the feature-map read address.
module fmap_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned PIXELS     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] chan_base,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    localparam int unsigned PIX_W = clog2_min1(PIXELS);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [PIX_W-1:0]      pix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            pix_q  <= '0;
        end else if (load) begin
            base_q <= chan_base;
            pix_q  <= '0;
        end else if (en) begin
            pix_q <= pix_q + PIX_W'(1);
        end
    end

    assign addr = base_q + ADDR_WIDTH'(pix_q);
    assign last = (pix_q == PIX_W'(PIXELS - 1));

endmodule

// File: rtl/conv_frame_sched.sv
// Walks (oc, ic) frame pairs: frame_start, raster stream from RAM, then drain window pulses.
module conv_frame_sched
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned IMG_WIDTH     = 32,
    parameter int unsigned IMG_HEIGHT    = 32,
    parameter int unsigned IN_CH         = 3,
    parameter int unsigned OUT_CH        = 8,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic                          frame_start,
    output logic [DATA_WIDTH-1:0]         pixel_out,
    output logic                          pixel_valid,
    input  logic                          window_valid,
    output logic                          acc_first,
    output logic                          acc_last,
    output logic [clog2_min1(OUT_CH)-1:0] oc_idx,
    output logic [clog2_min1(IN_CH)-1:0]  ic_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);
    localparam int unsigned FP    = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned OC_W  = clog2_min1(OUT_CH);
    localparam int unsigned IC_W  = clog2_min1(IN_CH);
    localparam int unsigned CNT_W = clog2_min1(FP + 1);
    localparam int unsigned TMO_W = clog2_min1(DRAIN_TIMEOUT);

    sched_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] chan_base;
    logic [CNT_W-1:0]      win_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  pv_q;
    logic                  pix_last;
    logic                  drained;
    logic                  timed_out;
    logic                  ic_last;
    logic                  oc_last;
    logic                  win_live;

    assign ic_last   = (ic_idx == IC_W'(IN_CH - 1));
    assign oc_last   = (oc_idx == OC_W'(OUT_CH - 1));
    assign drained   = (win_cnt >= CNT_W'(FP));
    assign timed_out = (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1));
    assign chan_base = base_q + ADDR_WIDTH'(ic_idx) * ADDR_WIDTH'(FP);

    fmap_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PIXELS     (FP)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state_q == FSTART),
        .en        (mem_rd_en),
        .chan_base (chan_base),
        .addr      (mem_addr),
        .last      (pix_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Strobes are gated by abort so they fall in the same cycle abort is seen.
    always_comb begin
        state_d     = state_q;
        mem_rd_en   = 1'b0;
        frame_start = 1'b0;
        pixel_valid = pv_q & ~abort;
        pixel_out   = '0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        win_live    = (state_q != IDLE) && (state_q != DONE);
        case (state_q)
            IDLE:    if (start) state_d = FSTART;
            FSTART: begin
                frame_start = ~abort;
                state_d     = STREAM;
            end
            STREAM: begin
                mem_rd_en = ~abort;
                if (pix_last) state_d = DRAIN;
            end
            DRAIN:   if (drained || timed_out) state_d = NEXT;
            NEXT:    state_d = (ic_last && oc_last) ? DONE : FSTART;
            DONE: begin
                done    = ~abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
        if (pixel_valid) pixel_out = mem_rd_data;
    end

    assign acc_first = window_valid & win_live & (ic_idx == '0);
    assign acc_last  = window_valid & win_live & ic_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            win_cnt <= '0;
            tmo_cnt <= '0;
            pv_q    <= 1'b0;
            error   <= 1'b0;
            oc_idx  <= '0;
            ic_idx  <= '0;
        end else begin
            pv_q <= mem_rd_en;
            if (abort) begin
                oc_idx <= '0;
                ic_idx <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        base_q <= base_addr;
                        error  <= 1'b0;
                    end
                    FSTART: win_cnt <= CNT_W'(window_valid);
                    STREAM: begin
                        tmo_cnt <= '0;
                        if (window_valid && win_cnt != '1) win_cnt <= win_cnt + CNT_W'(1);
                    end
                    DRAIN: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (window_valid && win_cnt != '1) win_cnt <= win_cnt + CNT_W'(1);
                        if (!drained && timed_out) error <= 1'b1;
                    end
                    NEXT: begin
                        if (ic_last) begin
                            ic_idx <= '0;
                            oc_idx <= oc_last ? '0 : oc_idx + OC_W'(1);
                        end else begin
                            ic_idx <= ic_idx + IC_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_sched.sv
// Directed-plus-random bench for conv_frame_sched with RAM and window-generator models.
module tb_conv_frame_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] salt;

    // instance 0: IN_CH=2, OUT_CH=2, 4x4, timeout 20
    logic        start0, abort0, rd_en0, fs0, pv0, wv0, af0, al0, busy0, done0, err0;
    logic [15:0] base0, addr0, rd_data0, pix0;
    logic [0:0]  oc0, ic0;
    // instance 1: IN_CH=1
    logic        start1, abort1, rd_en1, fs1, pv1, wv1, af1, al1, busy1, done1, err1;
    logic [15:0] base1, addr1, rd_data1, pix1;
    logic [0:0]  oc1, ic1;

    conv_frame_sched #(
        .DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4), .IN_CH(2), .OUT_CH(2),
        .ADDR_WIDTH(16), .DRAIN_TIMEOUT(20)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .base_addr(base0),
        .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(rd_data0),
        .frame_start(fs0), .pixel_out(pix0), .pixel_valid(pv0), .window_valid(wv0),
        .acc_first(af0), .acc_last(al0), .oc_idx(oc0), .ic_idx(ic0),
        .busy(busy0), .done(done0), .error(err0)
    );

    conv_frame_sched #(
        .DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4), .IN_CH(1), .OUT_CH(2),
        .ADDR_WIDTH(16), .DRAIN_TIMEOUT(20)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .base_addr(base1),
        .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(rd_data1),
        .frame_start(fs1), .pixel_out(pix1), .pixel_valid(pv1), .window_valid(wv1),
        .acc_first(af1), .acc_last(al1), .oc_idx(oc1), .ic_idx(ic1),
        .busy(busy1), .done(done1), .error(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ram_f(input logic [15:0] a);
        return (a * 16'h9E37) ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // RAM models: data one cycle after the read strobe, garbage otherwise
    always @(posedge clk) begin
        rd_data0 <= rd_en0 ? ram_f(addr0) : 16'($urandom);
        rd_data1 <= rd_en1 ? ram_f(addr1) : 16'($urandom);
    end

    // Window models: one window per pixel, two cycles later, capped per frame
    logic [1:0] pvd0, pvd1;
    int         win_sent0;
    int         win_limit0;
    assign wv0 = pvd0[1] && (win_sent0 < win_limit0);
    assign wv1 = pvd1[1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pvd0 <= '0; pvd1 <= '0; win_sent0 <= 0;
        end else begin
            pvd0 <= {pvd0[0], pv0};
            pvd1 <= {pvd1[0], pv1};
            if (fs0)      win_sent0 <= 0;
            else if (wv0) win_sent0 <= win_sent0 + 1;
        end
    end

    // Monitors (sample at negedge, away from the active edge)
    logic [15:0] addr_log0[$];
    logic [15:0] addr_log1[$];
    int rd_cyc0[$];
    int fs_cyc0[$];
    int cyc, fs_cnt0, pv_cnt0, done_cnt0, err_rise0, fidx0, exp_ic0;
    int fs_cnt1, done_cnt1, win_cnt1;
    logic rd_prev0, fs_prev0, busy_prev0, err_prev0;
    logic [15:0] addr_prev0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_prev0 = 1'b0; fs_prev0 = 1'b0; busy_prev0 = 1'b0; err_prev0 = 1'b0;
        end else begin
            cyc++;
            check("pv_trails_rd", pv0, rd_prev0 & ~abort0);
            if (pv0) check("pixel_data", pix0, ram_f(addr_prev0));
            if (fs_prev0 && !abort0) check("no_bubble", rd_en0, 1);
            if (busy0 && !busy_prev0) fidx0 = 0;
            if (fs0) begin
                fidx0++;
                fs_cnt0++;
                fs_cyc0.push_back(cyc);
                exp_ic0 = (fidx0 - 1) % 2;
                check("oc_at_fs", oc0, (fidx0 - 1) / 2);
                check("ic_at_fs", ic0, exp_ic0);
            end
            if (busy0 && !done0) begin
                check("acc_first", af0, wv0 && exp_ic0 == 0);
                check("acc_last", al0, wv0 && exp_ic0 == 1);
            end
            if (rd_en0) begin
                addr_log0.push_back(addr0);
                rd_cyc0.push_back(cyc);
            end
            if (pv0) pv_cnt0++;
            if (done0) done_cnt0++;
            if (err0 && !err_prev0) err_rise0 = cyc;
            rd_prev0 = rd_en0; addr_prev0 = addr0; fs_prev0 = fs0;
            busy_prev0 = busy0; err_prev0 = err0;
            // instance 1
            if (rd_en1) addr_log1.push_back(addr1);
            if (fs1) fs_cnt1++;
            if (done1) done_cnt1++;
            if (wv1 && busy1 && !done1) begin
                check("acc_first_1ch", af1, 1);
                check("acc_last_1ch", al1, 1);
                win_cnt1++;
            end
        end
    end

    task automatic check_zero0(input string tag);
        check({tag, "_rd_en"}, rd_en0, 0);
        check({tag, "_addr"}, addr0, 0);
        check({tag, "_fs"}, fs0, 0);
        check({tag, "_pv"}, pv0, 0);
        check({tag, "_pix"}, pix0, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_oc"}, oc0, 0);
        check({tag, "_ic"}, ic0, 0);
    endtask

    task automatic check_zero1(input string tag);
        check({tag, "_rd_en1"}, rd_en1, 0);
        check({tag, "_addr1"}, addr1, 0);
        check({tag, "_busy1"}, busy1, 0);
        check({tag, "_pv1"}, pv1, 0);
        check({tag, "_oc1"}, oc1, 0);
    endtask

    int snap_rd0, snap_fs0, snap_pv0, snap_done0;

    task automatic snap0;
        snap_rd0 = rd_cyc0.size(); snap_fs0 = fs_cnt0;
        snap_pv0 = pv_cnt0; snap_done0 = done_cnt0;
    endtask

    // Full layer on instance 0; frames in (oc,ic) order, ic = frame % 2.
    task automatic run0(input logic [15:0] base, input int limit, input logic exp_err);
        logic [15:0] exp_a;
        snap0();
        base0 = base; win_limit0 = limit;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt0 != snap_done0) break;
            tick();
        end
        check("done_once", done_cnt0 - snap_done0, 1);
        tick(); tick();
        check("frame_starts", fs_cnt0 - snap_fs0, 4);
        check("pixel_count", pv_cnt0 - snap_pv0, 64);
        check("read_count", rd_cyc0.size() - snap_rd0, 64);
        for (int i = 0; i < 64; i++) begin
            exp_a = base + 16'(((i / 16) % 2) * 16 + (i % 16));
            if (snap_rd0 + i < addr_log0.size()) check("addr", addr_log0[snap_rd0 + i], exp_a);
        end
        check("error_flag", err0, exp_err);
        check("idle_after", busy0, 0);
        check("done_once_total", done_cnt0 - snap_done0, 1);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        fs_cnt0 = 0; pv_cnt0 = 0; done_cnt0 = 0; err_rise0 = -1; fidx0 = 0; exp_ic0 = 0;
        fs_cnt1 = 0; done_cnt1 = 0; win_cnt1 = 0;
        salt = 16'($urandom);
        start0 = 0; abort0 = 0; base0 = 0; win_limit0 = 16;
        start1 = 0; abort1 = 0; base1 = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero0("reset");
        check_zero1("reset");
        rst_n = 1'b1;
        tick();

        // ideal window model, base 0x100
        run0(16'h0100, 16, 1'b0);

        // 15 windows per frame: each DRAIN times out after 20 cycles
        run0(16'($urandom), 15, 1'b1);
        if (snap_rd0 + 15 < rd_cyc0.size())
            check("err_rise_time", err_rise0, rd_cyc0[snap_rd0 + 15] + 21);
        if (snap_fs0 + 1 < fs_cyc0.size() && snap_rd0 + 15 < rd_cyc0.size())
            check("fs_after_timeout", fs_cyc0[snap_fs0 + 1], rd_cyc0[snap_rd0 + 15] + 22);
        repeat (5) tick();
        check("error_sticky", err0, 1);

        // abort mid-STREAM of (oc1, ic0)
        snap0();
        base0 = 16'h0100; win_limit0 = 16;
        start0 = 1'b1; tick(); start0 = 1'b0;
        check("error_cleared", err0, 0);
        for (int i = 0; i < 500; i++) begin
            if (fs_cnt0 - snap_fs0 == 3) break;
            tick();
        end
        check("reached_frame3", fs_cnt0 - snap_fs0, 3);
        repeat (4) tick();
        check("pre_abort_oc", oc0, 1);
        check("pre_abort_ic", ic0, 0);
        check("pre_abort_rd", rd_en0, 1);
        abort0 = 1'b1;
        #1;
        check("abort_rd_drop", rd_en0, 0);
        check("abort_fs_drop", fs0, 0);
        check("abort_pv_drop", pv0, 0);
        tick();
        abort0 = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_oc", oc0, 0);
        check("abort_ic", ic0, 0);
        check("abort_rd", rd_en0, 0);
        repeat (20) tick();
        check("abort_no_done", done_cnt0 - snap_done0, 0);
        check("abort_no_frames", fs_cnt0 - snap_fs0, 3);
        run0(16'h0100, 16, 1'b0);

        // reset asserted during DRAIN
        snap0();
        win_limit0 = 15;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pv_cnt0 - snap_pv0 >= 16) break;
            tick();
        end
        check("reached_drain", pv_cnt0 - snap_pv0, 16);
        repeat (5) tick();
        check("busy_in_drain", busy0, 1);
        #3 rst_n = 1'b0;
        #1;
        check_zero0("rst_drain");
        check_zero1("rst_drain");
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", busy0, 0);
        check("post_rst_no_done", done_cnt0 - snap_done0, 0);

        // IN_CH=1 instance; start pulses while busy must not disturb the layer
        base1 = 16'($urandom);
        begin
            int a_snap, f_snap, d_snap, w_snap;
            a_snap = addr_log1.size(); f_snap = fs_cnt1; d_snap = done_cnt1; w_snap = win_cnt1;
            start1 = 1'b1; tick(); start1 = 1'b0;
            repeat (10) tick();
            start1 = 1'b1; tick(); start1 = 1'b0;
            repeat (15) tick();
            start1 = 1'b1; tick(); start1 = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (done_cnt1 != d_snap) break;
                tick();
            end
            repeat (5) tick();
            check("ic1_done_once", done_cnt1 - d_snap, 1);
            check("ic1_frames", fs_cnt1 - f_snap, 2);
            check("ic1_windows", win_cnt1 - w_snap, 32);
            check("ic1_reads", addr_log1.size() - a_snap, 32);
            for (int i = 0; i < 32; i++) begin
                if (a_snap + i < addr_log1.size())
                    check("ic1_addr", addr_log1[a_snap + i], base1 + 16'(i % 16));
            end
            check("ic1_idle", busy1, 0);
            check("ic1_no_error", err1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
